wr_burst_buffer: RTL

- Sits directly downstream of the pixel-combining stage in the VDMA write path.
- Buffers the packed DSIZE-bit words (write strobe, data, line-end strobe) in a FIFO.
- Carves the buffered stream into AXI write bursts of at most BURST_LEN beats. A burst never crosses a line end.
- Presents a burst request (length) and then a valid/ready beat stream to the AXI write master.

---
 rtl/wr_burst_buffer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/wr_burst_buffer.sv
// Write-path burst buffer: FWFT data FIFO plus line-length FIFO, carving the stream into AXI bursts
// that never cross a line end. Define WR_BURST_TIMEOUT_EN to flush open-line residue after TIMEOUT idle cycles.
module wr_burst_buffer #(
    parameter int DSIZE     = 256,
    parameter int DEPTH     = 64,
    parameter int BURST_LEN = 16,
    parameter int SEGS      = 8,
    parameter int LEN_W     = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic                       clock,
    input  logic                       rst_n,
    input  logic                       iwr_en,
    input  logic [DSIZE-1:0]           idata,
    input  logic                       ilast_en,
    output logic                       oburst_req,
    output logic [8:0]                 oburst_len,
    input  logic                       iburst_ack,
    output logic                       ovalid,
    output logic [DSIZE-1:0]           odata,
    output logic                       olast,
    output logic                       oline_end,
    input  logic                       iready,
    output logic [$clog2(DEPTH):0]     ocount,
    output logic                       ofull,
    output logic                       ooverflow
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int SEG_PW = $clog2(SEGS);
    localparam int SEG_CW = SEG_PW + 1;
    localparam logic [8:0] BLEN = 9'(BURST_LEN);

    typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

    logic [DSIZE-1:0] mem_q [DEPTH];
    logic [LEN_W-1:0] seg_mem_q [SEGS];
    logic [DSIZE-1:0] odata_q, odata_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [SEG_PW-1:0] seg_wr_q, seg_wr_d, seg_rd_q, seg_rd_d;
    logic [SEG_CW-1:0] seg_cnt_q, seg_cnt_d;
    logic [LEN_W-1:0] line_beats_q, line_beats_d, head_used_q, head_used_d;
    logic             ovf_q, ovf_d;
    state_t           state_q, state_d;
    logic [8:0]       len_q, len_d, beat_q, beat_d, want_len;

    logic push, pop, last_hs, seg_push, seg_drop, seg_pop, seg_pending, seg_done, seg_skip;
    logic eligible, to_fire;
    logic [LEN_W-1:0] close_len, seg_head, rem, used_after, cnt_ext;

    assign cnt_ext     = LEN_W'(count_q);
    assign push        = iwr_en && (count_q != CNT_W'(DEPTH));
    assign pop         = (state_q == XFER) && (count_q != '0) && iready;
    assign last_hs     = pop && (beat_q == len_q - 9'd1);
    assign close_len   = line_beats_q + LEN_W'(push);
    assign seg_push    = ilast_en && (close_len != '0) && (seg_cnt_q != SEG_CW'(SEGS));
    assign seg_drop    = ilast_en && (close_len != '0) && (seg_cnt_q == SEG_CW'(SEGS));
    assign seg_pending = (seg_cnt_q != '0);
    assign seg_head    = seg_mem_q[seg_rd_q];
    assign rem         = seg_head - head_used_q;
    assign used_after  = head_used_q + LEN_W'(len_q);
    // Line-end is judged when the burst finishes, so a line closed mid-burst is still flagged.
    assign seg_done    = seg_pending && (used_after == seg_head);
    assign seg_skip    = (state_q == IDLE) && seg_pending && (rem == '0);
    assign seg_pop     = (last_hs && seg_done) || seg_skip;

`ifdef WR_BURST_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] idle_q, idle_d;
    logic            idle_run;

    assign idle_run = (state_q == IDLE) && !seg_pending && (count_q != '0) &&
                      (cnt_ext < LEN_W'(BURST_LEN));
    assign to_fire  = idle_run && (idle_q == TO_W'(TIMEOUT));

    always_comb begin
        idle_d = '0;
        if (idle_run && !iwr_en)
            idle_d = (idle_q == TO_W'(TIMEOUT)) ? idle_q : idle_q + 1'b1;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) idle_q <= '0;
        else        idle_q <= idle_d;
    end
`else
    assign to_fire = 1'b0;
`endif

    always_comb begin
        want_len = BLEN;
        eligible = 1'b0;
        if (seg_pending) begin
            want_len = (rem >= LEN_W'(BURST_LEN)) ? BLEN : rem[8:0];
            eligible = (rem != '0) && (cnt_ext >= LEN_W'(want_len));
        end else if (to_fire) begin
            want_len = 9'(count_q);
            eligible = 1'b1;
        end else begin
            eligible = (cnt_ext >= LEN_W'(BURST_LEN));
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        beat_d      = beat_q;
        head_used_d = head_used_q;
        case (state_q)
            IDLE: begin
                if (seg_skip) begin
                    head_used_d = '0;
                end else if (eligible) begin
                    len_d   = want_len;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (iburst_ack) begin
                    beat_d  = '0;
                    state_d = XFER;
                end
            end
            XFER: begin
                if (pop) beat_d = beat_q + 9'd1;
                if (last_hs) begin
                    head_used_d = seg_done ? '0 : used_after;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d     = wr_ptr_q + PTR_W'(push);
        rd_ptr_d     = rd_ptr_q + PTR_W'(pop);
        count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
        // Output register tracks the next head word; bypass when that word is being written now.
        odata_d      = (push && (wr_ptr_q == rd_ptr_d)) ? idata : mem_q[rd_ptr_d];
        seg_wr_d     = seg_wr_q + SEG_PW'(seg_push);
        seg_rd_d     = seg_rd_q + SEG_PW'(seg_pop);
        seg_cnt_d    = seg_cnt_q + SEG_CW'(seg_push) - SEG_CW'(seg_pop);
        line_beats_d = ilast_en ? '0 : close_len;
        ovf_d        = ovf_q | (iwr_en && !push) | seg_drop;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            len_q        <= '0;
            beat_q       <= '0;
            head_used_q  <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            seg_wr_q     <= '0;
            seg_rd_q     <= '0;
            seg_cnt_q    <= '0;
            line_beats_q <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            beat_q       <= beat_d;
            head_used_q  <= head_used_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            seg_wr_q     <= seg_wr_d;
            seg_rd_q     <= seg_rd_d;
            seg_cnt_q    <= seg_cnt_d;
            line_beats_q <= line_beats_d;
            ovf_q        <= ovf_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push)     mem_q[wr_ptr_q]     <= idata;
        if (seg_push) seg_mem_q[seg_wr_q] <= close_len;
        odata_q <= odata_d;
    end

    assign oburst_req = (state_q == REQ);
    assign oburst_len = (state_q == IDLE) ? 9'd0 : len_q;
    assign ovalid     = (state_q == XFER) && (count_q != '0);
    assign olast      = ovalid && (beat_q == len_q - 9'd1);
    assign oline_end  = olast && seg_done;
    assign odata      = odata_q;
    assign ocount     = count_q;
    assign ofull      = (count_q == CNT_W'(DEPTH));
    assign ooverflow  = ovf_q;
endmodule
